// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback and runs loads/stores over a req/ack port.
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops raise exc_misalign instead of accessing memory.
module mem_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ack,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_data,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_reg_write,
  output logic             exc_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } dst_t;

  state_t state, state_nxt;
  dst_t   dst_q;
  logic   accept, is_mem, misalign;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_ready & ex_valid & ~flush;
  assign is_mem   = ex_mem_read | ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & (ex_result[1:0] != 2'b00);
`else
  // Low address bits are dropped: the access goes to the enclosing word.
  logic unused_addr_lo;
  assign unused_addr_lo = ^ex_result[1:0];
  assign misalign       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && is_mem && !misalign) state_nxt = REQ;
      REQ:     if (dmem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dst_q        <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      exc_misalign <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      exc_misalign <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_mem && !misalign) begin
            // Store wins when both read and write are set.
            dmem_req         <= 1'b1;
            dmem_we          <= ex_mem_write;
            dmem_addr        <= {ex_result[XLEN-1:2], 2'b00};
            dmem_wdata       <= ex_store_data;
            dst_q.rd         <= ex_rd;
            dst_q.reg_write  <= ex_reg_write;
          end else begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write & ~misalign;
            exc_misalign <= misalign;
          end
        end
        REQ: if (dmem_ack) begin
          dmem_req     <= 1'b0;
          wb_valid     <= 1'b1;
          wb_data      <= dmem_we ? '0 : dmem_rdata;
          wb_rd        <= dst_q.rd;
          wb_reg_write <= dst_q.reg_write & ~dmem_we;
        end
        default: ;
      endcase
    end
  end

endmodule
